// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bundle between two masters and mem_arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface mem_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
) ();
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;

    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, ack1, rdata, err
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, ack1, rdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a shared RAM with a
// bidirectional data bus. Each access runs IDLE -> SETUP -> STROBE -> DONE; all
// outputs come straight from registers.
module mem_arbiter #(
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_read,
    output logic           mem_write,
    inout  wire  [DW-1:0]  mem_data
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StStrobe = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DepthLim = DEPTH[AW:0];

    logic [1:0]    state_q, state_d;
    logic          port_q, port_d;
    logic          we_q, we_d;
    logic          oor_q, oor_d;
    logic          last_gnt_q, last_gnt_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          drive_q, drive_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          sel_port;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oor;

    // Round-robin pick: on a tie the port that did not win last time is granted.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            sel_port = ~last_gnt_q;
        end else begin
            sel_port = bus.req1;
        end
        sel_we    = sel_port ? bus.we1    : bus.we0;
        sel_addr  = sel_port ? bus.addr1  : bus.addr0;
        sel_wdata = sel_port ? bus.wdata1 : bus.wdata0;
        sel_oor   = ({1'b0, sel_addr} >= DepthLim);
    end

    // Access sequencer: next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        we_d       = we_q;
        oor_d      = oor_q;
        last_gnt_d = last_gnt_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        drive_d    = drive_q;
        rdata_d    = rdata_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            StIdle: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                drive_d = 1'b0;
                if (bus.req0 || bus.req1) begin
                    port_d     = sel_port;
                    last_gnt_d = sel_port;
                    we_d       = sel_we;
                    oor_d      = sel_oor;
                    wdata_d    = sel_wdata;
                    mem_addr_d = sel_addr;
                    // Out-of-range requests never touch the RAM strobes or bus.
                    drive_d    = sel_we & ~sel_oor;
                    rd_d       = ~sel_we & ~sel_oor;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                wr_d    = we_q & ~oor_q;
                state_d = StStrobe;
            end
            StStrobe: begin
                wr_d = 1'b0;
                rd_d = 1'b0;
                if (!we_q && !oor_q) begin
                    rdata_d = mem_data;
                end
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                err_d   = oor_q;
                state_d = StDone;
            end
            default: begin
                // DONE: write data held one more cycle, released on the way to IDLE.
                drive_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            drive_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            we_q       <= we_d;
            oor_q      <= oor_d;
            last_gnt_q <= last_gnt_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            drive_q    <= drive_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_data  = drive_q ? wdata_q : {DW{1'bz}};
    assign mem_addr  = mem_addr_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked cycle by cycle against a transaction-level timeline model.
module tb_mem_arbiter;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    wire  [DW-1:0] mem_data;

    mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_data  (mem_data)
    );

    // Behavioural RAM: level-sensitive read, write on rising strobe.
    logic [DW-1:0] ram [DEPTH] = '{8'h5A, 8'hC3, 8'h0F, 8'h96, 8'h21, 8'hE7, 8'h48, 8'hB2};
    assign mem_data = mem_read ? ram[mem_addr[2:0]] : {DW{1'bz}};
    always @(posedge mem_write) begin
        if (int'(mem_addr) < DEPTH) ram[mem_addr[2:0]] <= mem_data;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH] = '{8'h5A, 8'hC3, 8'h0F, 8'h96, 8'h21, 8'hE7, 8'h48, 8'hB2};
    logic [DW-1:0] rdata_m;
    int            last_gnt_m;
    int            tests = 0;
    int            fails = 0;

    typedef struct {
        bit            v;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    function automatic acc_t mk(input bit v, input bit we, input int addr, input int data);
        acc_t a;
        a.v    = v;
        a.we   = we;
        a.addr = AW'(addr);
        a.data = DW'(data);
        return a;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ctl_vec();
        return {11'd0, bus.ack0, bus.ack1, bus.err, mem_read, mem_write};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, " ctl"}, ctl_vec(), 16'd0);
        check({tag, " bus"}, {8'd0, mem_data}, {8'd0, 8'hzz});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset rdata", {8'd0, bus.rdata}, 16'd0);
        check("reset addr", {11'd0, mem_addr}, 16'd0);
        rst        = 1'b0;
        last_gnt_m = 1;
        rdata_m    = '0;
    endtask

    // Entered at a negedge with the DUT in IDLE; leaves at the next IDLE negedge.
    task automatic run(input acc_t a0, input acc_t a1);
        acc_t acc [2];
        int   first, second, ncyc;
        acc[0] = a0;
        acc[1] = a1;
        if (a0.v && a1.v) begin
            first  = (last_gnt_m == 1) ? 0 : 1;
            second = 1 - first;
        end else begin
            first  = a0.v ? 0 : 1;
            second = -1;
        end
        last_gnt_m = (second >= 0) ? second : first;
        ncyc = (second >= 0) ? 7 : 3;

        bus.req0 = a0.v; bus.we0 = a0.we; bus.addr0 = a0.addr; bus.wdata0 = a0.data;
        bus.req1 = a1.v; bus.we1 = a1.we; bus.addr1 = a1.addr; bus.wdata1 = a1.data;

        for (int n = 1; n <= ncyc; n++) begin
            int       port, p;
            bit       oor;
            logic [4:0]    e_ctl;
            logic [DW-1:0] e_data;
            acc_t     a;
            @(negedge clk);
            port   = (n <= 3) ? first : ((n == 4) ? -1 : second);
            p      = (n <= 3) ? n : n - 4;
            e_ctl  = '0;
            e_data = {DW{1'bz}};
            if (port >= 0) begin
                a   = acc[port];
                oor = (int'(a.addr) >= DEPTH);
                if (!oor && a.we) begin
                    e_data   = a.data;
                    e_ctl[0] = (p == 2);
                end
                if (!oor && !a.we && p < 3) begin
                    e_ctl[1] = 1'b1;
                    e_data   = ref_mem[a.addr[2:0]];
                end
                check($sformatf("addr n=%0d", n), {11'd0, mem_addr}, {11'd0, a.addr});
                if (p == 3) begin
                    e_ctl[4] = (port == 0);
                    e_ctl[3] = (port == 1);
                    e_ctl[2] = oor;
                    if (!oor && !a.we) rdata_m = ref_mem[a.addr[2:0]];
                    if (!oor && a.we) ref_mem[a.addr[2:0]] = a.data;
                    check($sformatf("rdata p%0d a%0d", port, a.addr), {8'd0, bus.rdata},
                          {8'd0, rdata_m});
                    if (port == 0) bus.req0 = 1'b0;
                    else bus.req1 = 1'b0;
                end
            end
            check($sformatf("ctl n=%0d", n), ctl_vec(), {11'd0, e_ctl});
            check($sformatf("bus n=%0d", n), {8'd0, mem_data}, {8'd0, e_data});
        end
        @(negedge clk);
        check_quiet("idle");
    endtask

    acc_t none;

    initial begin
        none = mk(0, 0, 0, 0);
        bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        do_reset();

        // Write then read back through port 0.
        run(mk(1, 1, 3, 8'hA5), none);
        run(mk(1, 0, 3, 0), none);

        // Ties alternate starting with port 0.
        do_reset();
        run(mk(1, 1, 4, 8'h44), mk(1, 1, 5, 8'h55));
        run(mk(1, 0, 5, 0), mk(1, 0, 4, 0));

        // Out-of-range write and read on port 1, then readback of word 1.
        run(none, mk(1, 1, 9, 8'hEE));
        run(none, mk(1, 0, 9, 0));
        run(none, mk(1, 0, 1, 0));

        // Write on port 0 immediately followed by a read of the same word on port 1.
        run(mk(1, 1, 7, 8'h3C), mk(1, 0, 7, 0));

        // Reset during SETUP of a write: no strobe, no ack, bus released.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd2; bus.wdata0 = 8'hFF;
        @(negedge clk);
        check("abort setup ctl", ctl_vec(), 16'd0);
        check("abort setup bus", {8'd0, mem_data}, 16'h00FF);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        check_quiet("abort reset");
        rst = 1'b0;
        last_gnt_m = 1;
        rdata_m    = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("abort after");
        end
        run(mk(1, 0, 2, 0), none);

        // Fill all words then read back alternating ports.
        for (int i = 0; i < DEPTH; i++) run(mk(1, 1, i, i * 8'h11), none);
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) run(mk(1, 0, i, 0), none);
            else run(none, mk(1, 0, i, 0));
        end

        // Random traffic including ties and out-of-range addresses.
        for (int k = 0; k < 40; k++) begin
            int m;
            acc_t r0, r1;
            m  = $urandom_range(1, 3);
            r0 = mk(m[0], 1'($urandom), $urandom_range(0, 9), $urandom);
            r1 = mk(m[1], 1'($urandom), $urandom_range(0, 9), $urandom);
            run(r0, r1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
